key_reg_writer: RTL

Front-panel input block for the 8-bit CPU board, the write-side counterpart of the LED register display. It synchronises and debounces the four active-low push keys, turns each debounced press into a register-write request, and drives a req/ack write port into the register file. Key 0..3 selects ax/bx/cx/dx; the written value is the 4-bit switch input, zero-extended to 8 bits.

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_debounce.sv | 45 ++++
 rtl/key_reg_writer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the front-panel key writer: FSM states,
// register-select codes and counter width sizing.
package key_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [1:0] SEL_AX = 2'd0;
  localparam logic [1:0] SEL_BX = 2'd1;
  localparam logic [1:0] SEL_CX = 2'd2;
  localparam logic [1:0] SEL_DX = 2'd3;

  // Bits needed for a counter that runs 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push key: 2-flop synchroniser on the active-low raw input followed by a
// counter that only accepts a level after DEBOUNCE_CYCLES stable cycles.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level
);

  localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          synced;
  logic [CW-1:0] cnt;

  assign synced = ~sync_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      // debounce stage: any disagreement that does not last restarts the count
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_reg_writer.sv
// Debounced front-panel keys -> register-file write requests (req/ack port).
// Optional auto-repeat of a held key is built when KEY_AUTOREPEAT_EN is defined.
module key_reg_writer
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  input  logic [3:0] sw_in,
  output logic       wr_req,
  output logic [1:0] wr_sel,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  output logic [3:0] key_state,
  output logic       busy
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] key_state_p1;
  logic [3:0] pending;
  logic [3:0] press;
  logic [3:0] clr;
  logic [3:0] rpt_set;
  logic       grant;
  logic [1:0] gnt_sel;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .key_n(key_in[i]),
      .level(key_state[i])
    );
  end

  assign press  = key_state & ~key_state_p1;
  assign wr_req = (state == REQ);
  assign busy   = (pending != 4'h0) || wr_req;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    clr       = 4'h0;
    // later assignments win, so key 3 has highest priority
    gnt_sel = SEL_AX;
    if (pending[1]) gnt_sel = SEL_BX;
    if (pending[2]) gnt_sel = SEL_CX;
    if (pending[3]) gnt_sel = SEL_DX;
    case (state)
      IDLE: begin
        if (pending != 4'h0) begin
          grant     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (wr_ack) begin
          clr[wr_sel] = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_sel       <= SEL_AX;
      wr_data      <= 8'h00;
      key_state_p1 <= 4'h0;
      pending      <= 4'h0;
    end else begin
      state        <= state_nxt;
      key_state_p1 <= key_state;
      pending      <= (pending & ~clr) | press | rpt_set;
      if (grant) begin
        wr_sel  <= gnt_sel;
        wr_data <= {4'h0, sw_in};
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int            RW      = cnt_w(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

  logic          rpt_on;
  logic [1:0]    rpt_key;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_kill;

  assign rpt_kill = !key_state[rpt_key] || (grant && (gnt_sel != rpt_key));
  assign rpt_set  = (rpt_on && !rpt_kill && (rpt_cnt == RPT_MAX)) ? (4'b0001 << rpt_key) : 4'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_on  <= 1'b0;
      rpt_key <= SEL_AX;
      rpt_cnt <= '0;
    end else if (wr_req && wr_ack) begin
      rpt_on  <= key_state[wr_sel];
      rpt_key <= wr_sel;
      rpt_cnt <= '0;
    end else if (rpt_on) begin
      if (rpt_kill || (rpt_cnt == RPT_MAX)) begin
        rpt_on  <= 1'b0;
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  // No timer in this build; the repeat period only appears in this constant.
  assign rpt_set = (REPEAT_CYCLES < 0) ? 4'hF : 4'h0;
`endif

endmodule
